bnn_param_loader: RTL and testbench

Sequencer that loads weights and biases into a daisy-chained column of BNN neurons through their serial `setup`/`param_in`/`param_out` configuration port. It accepts parameter bytes on a valid/ready stream, serialises them MSB-first, and asserts `setup` for exactly one cycle per chain bit. Host-side stalls never corrupt the chain. It sits between the chip's byte-wide input pins and the neuron layer.

---
 rtl/bnn_param_loader_if.sv | 15 +
 rtl/bnn_param_loader.sv | 167 ++++++++++++++++
 tb/tb_bnn_param_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_param_loader_if.sv
// bnn_param_loader_if
//   Byte stream from the chip's parameter input pins into the loader.
//   Ports (signals):
//     in_valid  host -> loader  parameter byte valid
//     in_data   host -> loader  parameter byte, MSB shifted into the chain first
//     in_ready  loader -> host  loader can take a byte this cycle
//   Modports: master (host side), slave (loader side).
interface bnn_param_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bnn_param_loader.sv
// bnn_param_loader
//   Loads weights and biases into a daisy-chained column of BNN neurons
//   through their serial setup/param_in/param_out port. Bytes arrive on a
//   valid/ready stream, are shifted MSB-first, and setup is high for exactly
//   one cycle per chain bit. Host stalls only stretch FETCH; the chain never
//   sees a spurious shift.
//
//   Parameters: NEURONS, INPUTS (weight bits/neuron), BIAS_BITS.
//   Ports:
//     clk        single clock, posedge
//     reset      asynchronous, active-high
//     start      level; begins a load when idle
//     in_bus     slave side of the parameter byte stream
//     setup      registered shift enable to every neuron
//     param_in   registered serial bit to the first neuron
//     chain_out  param_out of the last neuron
//     busy       high from the cycle after start is accepted through done
//     done       one-cycle pulse at load completion
//     rd_valid   readback byte strobe (0 unless readback is built)
//     rd_data    readback byte        (0 unless readback is built)
//
//   Build option: define BNN_LOADER_READBACK_EN to capture the old chain
//   contents from chain_out while a new load shifts in.
module bnn_param_loader #(
  parameter int unsigned NEURONS   = 4,
  parameter int unsigned INPUTS    = 8,
  parameter int unsigned BIAS_BITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  bnn_param_loader_if.slave   in_bus,
  output logic                setup,
  output logic                param_in,
  input  logic                chain_out,
  output logic                busy,
  output logic                done,
  output logic                rd_valid,
  output logic [7:0]          rd_data
);

  localparam int unsigned CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int unsigned CNT_W      = $clog2(CHAIN_BITS + 1);
  localparam logic [CNT_W-1:0] CHAIN_BITS_C = CNT_W'(CHAIN_BITS);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [CNT_W-1:0] bits_sent, bits_sent_nxt;
  logic [CNT_W-1:0] bits_left;
  logic [3:0]       byte_left, byte_left_nxt;
  logic             accept;

  logic setup_nxt, param_in_nxt, ready_nxt, busy_nxt, done_nxt;

  assign accept = in_bus.in_ready && in_bus.in_valid;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      shreg           <= '0;
      bits_sent       <= '0;
      byte_left       <= '0;
      setup           <= 1'b0;
      param_in        <= 1'b0;
      in_bus.in_ready <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nxt;
      shreg           <= shreg_nxt;
      bits_sent       <= bits_sent_nxt;
      byte_left       <= byte_left_nxt;
      setup           <= setup_nxt;
      param_in        <= param_in_nxt;
      in_bus.in_ready <= ready_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bits_sent_nxt = bits_sent;
    byte_left_nxt = byte_left;
    bits_left     = CHAIN_BITS_C - bits_sent;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = FETCH;
          bits_sent_nxt = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          state_nxt     = SHIFT;
          shreg_nxt     = in_bus.in_data;
          // Final partial byte: only its top bits are shifted.
          byte_left_nxt = (32'(bits_left) >= 32'd8) ? 4'd8 : 4'(bits_left);
        end
      end
      SHIFT: begin
        shreg_nxt     = {shreg[6:0], 1'b0};
        bits_sent_nxt = bits_sent + CNT_W'(1);
        byte_left_nxt = byte_left - 4'd1;
        if (byte_left == 4'd1)
          state_nxt = (bits_sent_nxt == CHAIN_BITS_C) ? FINISH : FETCH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is
  // a clean flop that lines up with the state it describes.
  always_comb begin
    setup_nxt    = (state_nxt == SHIFT);
    param_in_nxt = (state_nxt == SHIFT) ? shreg_nxt[7] : 1'b0;
    ready_nxt    = (state_nxt == FETCH);
    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state_nxt == FINISH);
  end

`ifdef BNN_LOADER_READBACK_EN
  logic [6:0] rb_sh;
  logic [2:0] rb_cnt;
  logic [7:0] rb_word;

  // chain_out is sampled on every edge where the neurons shift.
  assign rb_word = {rb_sh, chain_out};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_sh    <= '0;
      rb_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == IDLE && start) begin
        rb_cnt <= '0;
      end else if (setup) begin
        rb_sh  <= rb_word[6:0];
        rb_cnt <= rb_cnt + 3'd1;
        if (rb_cnt == 3'd7) begin
          rd_valid <= 1'b1;
          rd_data  <= rb_word;
        end else if (state_nxt == FINISH) begin
          // Trailing partial byte, left-justified, emitted alongside done.
          rd_valid <= 1'b1;
          rd_data  <= rb_word << (3'd7 - rb_cnt);
        end
      end
    end
  end
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign rd_valid = 1'b0;
  assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
module tb_bnn_param_loader;

  localparam int unsigned NB = 44;
  localparam logic [47:0] LOAD_BYTES = 48'hA53C_FF00_81E0;
  localparam logic [NB-1:0] LOAD_CHAIN = 44'hA53_CFF0_081E;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic chain_out;
  logic setup, param_in, busy, done, rd_valid;
  logic [7:0] rd_data;

  bnn_param_loader_if bus ();

  bnn_param_loader #(.NEURONS(4), .INPUTS(8), .BIAS_BITS(3)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_bus    (bus),
    .setup     (setup),
    .param_in  (param_in),
    .chain_out (chain_out),
    .busy      (busy),
    .done      (done),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input bit ok,
                     input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Neuron column model: no reset, shifts on setup; chain[43] is the last
  // neuron's bias MSB and feeds chain_out.
  logic [NB-1:0] chain = '0;
  int setup_edges = 0;
  always @(posedge clk) begin
    if (setup) begin
      chain       <= {chain[NB-2:0], param_in};
      setup_edges <= setup_edges + 1;
    end
  end
  assign chain_out = chain[NB-1];

  // Scoreboards.
  bit         exp_bits[$];
  logic [7:0] exp_rd[$];
  int done_cnt = 0;
  int rd_seen = 0;
  int rd_cnt = 0;
  bit rb_check = 1'b0;
  logic rd_last_done = 1'b0;

  always @(negedge clk) begin
    bit         eb;
    logic [7:0] er;
    if (setup) begin
      chk("setup_budget", exp_bits.size() > 0, exp_bits.size(), 1);
      if (exp_bits.size() > 0) begin
        eb = exp_bits.pop_front();
        chk("param_in", param_in === eb, param_in, eb);
      end
    end
    if (done) done_cnt++;
    if (rd_valid) begin
      rd_seen++;
      if (rb_check) begin
        rd_cnt++;
        rd_last_done = done;
        chk("rd_avail", exp_rd.size() > 0, exp_rd.size(), 1);
        if (exp_rd.size() > 0) begin
          er = exp_rd.pop_front();
          chk("rd_data", rd_data === er, rd_data, er);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called at a negedge with in_valid low. gap>0 holds in_valid low for that
  // many FETCH cycles before offering the byte.
  task automatic drive_byte(input logic [7:0] b, input int gap, input int nbits);
    int budget;
    for (int i = 0; i < nbits; i++) exp_bits.push_back(b[7-i]);
    if (gap > 0) begin
      budget = 0;
      while (!bus.in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      for (int g = 0; g < gap; g++) begin
        chk("gap_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
        chk("gap_setup", setup === 1'b0, setup, 0);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (!bus.in_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk("accept_timeout", bus.in_ready === 1'b1, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_load(input logic [47:0] bytes, input logic [NB-1:0] exp_chain,
                          input logic [5:0] gap_mask, input int restart_idx,
                          input bit restart_after, input int exp_lat);
    int t0, t1, budget;
    logic [7:0] bv;
    setup_edges = 0;
    done_cnt    = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = int'(cyc);
    chk("fetch_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
    chk("fetch_busy", busy === 1'b1, busy, 1);
    for (int i = 0; i < 6; i++) begin
      bv = bytes[47-8*i -: 8];
      if (i == restart_idx) start = 1'b1;
      drive_byte(bv, gap_mask[i] ? 5 : 0, (i == 5) ? 4 : 8);
      start = 1'b0;
    end
    budget = 0;
    while (!done && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    t1 = int'(cyc);
    chk("done_seen", done === 1'b1, done, 1);
    chk("done_latency", (t1 - t0) == exp_lat, t1 - t0, exp_lat);
    if (restart_after) start = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy === 1'b0, busy, 0);
    chk("idle_done", done === 1'b0, done, 0);
    chk("idle_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
    chk("setup_count", setup_edges == NB, setup_edges, NB);
    chk("done_count", done_cnt == 1, done_cnt, 1);
    chk("chain", chain === exp_chain, chain, exp_chain);
    chk("bits_left", exp_bits.size() == 0, exp_bits.size(), 0);
    if (restart_after) begin
      @(negedge clk);
      start = 1'b0;
      chk("restart_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
      chk("restart_busy", busy === 1'b1, busy, 1);
    end
  endtask

  initial begin
    int budget;
    logic [7:0] bv;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Async reset in the middle of a cycle while in FETCH.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_reset_ready", bus.in_ready === 1'b1, bus.in_ready, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
    chk("rst_busy", busy === 1'b0, busy, 0);
    chk("rst_done", done === 1'b0, done, 0);
    chk("rst_setup", setup === 1'b0, setup, 0);
    chk("rst_param_in", param_in === 1'b0, param_in, 0);
    chk("rst_rd_valid", rd_valid === 1'b0, rd_valid, 0);
    chk("rst_rd_data", rd_data === 8'h00, rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_ready", bus.in_ready === 1'b0, bus.in_ready, 0);

    // Full load, no gaps: done 50 edges after the start-sampling edge.
    run_load(LOAD_BYTES, LOAD_CHAIN, 6'b000000, -1, 1'b0, 50);
    chk("n3_bias", chain[43:41] === 3'b101, chain[43:41], 3'b101);
    chk("n3_weights", chain[40:33] === 8'h29, chain[40:33], 8'h29);
    chk("n0_bias", chain[10:8] === 3'b000, chain[10:8], 3'b000);
    chk("n0_weights", chain[7:0] === 8'h1E, chain[7:0], 8'h1E);

    // Backpressure before bytes 2 and 4: ten extra FETCH cycles.
    chain = '0;
    run_load(LOAD_BYTES, LOAD_CHAIN, 6'b010100, -1, 1'b0, 60);

    // Start held during a load, then restart right after IDLE.
    chain = '0;
    run_load(LOAD_BYTES, LOAD_CHAIN, 6'b000000, 2, 1'b1, 50);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy === 1'b0, busy, 0);
    chk("abort_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset after 20 bits have entered the chain.
    chain = '0;
    setup_edges = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bv = LOAD_BYTES[47-8*i -: 8];
      drive_byte(bv, 0, 8);
    end
    budget = 0;
    while (setup_edges < 20 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_bits", setup_edges == 20, setup_edges, 20);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", busy === 1'b0, busy, 0);
    chk("mid_ready", bus.in_ready === 1'b0, bus.in_ready, 0);
    chk("mid_setup", setup === 1'b0, setup, 0);
    chk("mid_partial", chain[19:0] === 20'hA53CF, chain[19:0], 20'hA53CF);
    exp_bits.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(LOAD_BYTES, LOAD_CHAIN, 6'b000000, -1, 1'b0, 50);

`ifdef BNN_LOADER_READBACK_EN
    // Reload zeros; the previous contents come back out on rd_data.
    for (int i = 0; i < 6; i++) begin
      bv = LOAD_BYTES[47-8*i -: 8];
      exp_rd.push_back(bv);
    end
    rd_cnt   = 0;
    rb_check = 1'b1;
    run_load(48'h0, '0, 6'b000000, -1, 1'b0, 50);
    rb_check = 1'b0;
    chk("rd_pulses", rd_cnt == 6, rd_cnt, 6);
    chk("rd_last_with_done", rd_last_done === 1'b1, rd_last_done, 1);
    chk("rd_left", exp_rd.size() == 0, exp_rd.size(), 0);
`else
    chk("rd_never", rd_seen == 0, rd_seen, 0);
    chk("rd_data_tied", rd_data === 8'h00, rd_data, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
